// File: rtl/demux_tdm_1x4_pkg.sv
// Shared definitions for the TDM receive demultiplexer.
//  - FSM state encodings (one bit: hunting for alignment, or locked)
//  - legal range of the channel count
//  - helper that builds a one-hot channel strobe
package demux_tdm_1x4_pkg;

  localparam logic ST_HUNT   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  localparam int N_CH_MIN = 2;
  localparam int N_CH_MAX = 16;

  // One-hot strobe for slot 'sel' in a field of up to N_CH_MAX channels;
  // the caller truncates to its own channel count.
  function automatic logic [N_CH_MAX-1:0] onehot_slot(input logic [3:0] sel);
    logic [N_CH_MAX-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_tdm_1x4_if.sv
// Bus bundle for the TDM receive demultiplexer.
//
// Handshake: din_valid is a valid-only qualifier. There is no ready; the
// receiver accepts every word presented with din_valid=1, in the same cycle.
// din and frame_sync are meaningful only while din_valid=1. The output side
// is pulse/level based: ch_strobe, frame_valid and sync_err are one-cycle
// pulses, ch_data/ch_sel/locked are held levels.
//
// Signals:
//  din_valid, din, frame_sync  : incoming TDM stream (driven by master)
//  ch_data                     : last complete frame, channel k at [k*WIDTH +: WIDTH]
//  ch_strobe, ch_sel           : per-word capture pulse and slot index
//  frame_valid, locked, sync_err : frame/alignment status
//  dbg_state                   : current FSM state for observation
interface demux_tdm_1x4_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
) ();
  localparam int SEL_W = $clog2(N_CH);

  logic                  din_valid;
  logic [WIDTH-1:0]      din;
  logic                  frame_sync;
  logic [N_CH*WIDTH-1:0] ch_data;
  logic [N_CH-1:0]       ch_strobe;
  logic [SEL_W-1:0]      ch_sel;
  logic                  frame_valid;
  logic                  locked;
  logic                  sync_err;
  logic                  dbg_state;

  modport master (
    output din_valid, din, frame_sync,
    input  ch_data, ch_strobe, ch_sel, frame_valid, locked, sync_err, dbg_state
  );

  modport slave (
    input  din_valid, din, frame_sync,
    output ch_data, ch_strobe, ch_sel, frame_valid, locked, sync_err, dbg_state
  );
endinterface

// File: rtl/demux_tdm_1x4_mod_n_counter.sv
// Modulus-MOD slot counter.
// Ports:
//  clk, rst : clock, synchronous active-high reset (count -> 0)
//  en       : advance by one, wrapping from MOD-1 to 0
//  load1    : load the value 1 (takes priority over en)
//  cnt      : current count
//  wrap     : combinational, high when en is set while cnt = MOD-1
module mod_n_counter #(
  parameter int W   = 2,
  parameter int MOD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load1,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= W'(1);
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end
endmodule

// File: rtl/demux_tdm_1x4.sv
// Receive side of a word-interleaved TDM link. Locks to frame_sync, steers
// each accepted word into its channel slot and publishes a coherent frame on
// ch_data with a one-cycle frame_valid pulse.
// Ports:
//  clk  : rising-edge clock
//  rst  : synchronous active-high reset
//  bus  : demux_tdm_1x4_if.slave (stream in, channel bank and status out)
module demux_tdm_1x4
  import demux_tdm_1x4_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4
) (
  input logic          clk,
  input logic          rst,
  demux_tdm_1x4_if.slave bus
);
  localparam int SEL_W = $clog2(N_CH);

  generate
    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX) begin : g_bad_n_ch
      $error("demux_tdm_1x4: N_CH out of range 2..16");
    end
  endgenerate

  logic             state;
  logic [SEL_W-1:0] slot;
  logic             cnt_en;
  logic             cnt_load;
  logic             cnt_wrap;
  // Channel N_CH-1 is never buffered: it goes straight into ch_data.
  logic [WIDTH-1:0] work [N_CH-1];

  // Counter control. A sync word always restarts the frame at slot 1;
  // a missing sync at slot 0 leaves the counter parked at 0 for HUNT.
  always_comb begin
    cnt_en   = 1'b0;
    cnt_load = 1'b0;
    if (bus.din_valid) begin
      if (state == ST_HUNT) begin
        cnt_load = bus.frame_sync;
      end else if (slot == '0) begin
        cnt_en = bus.frame_sync;
      end else begin
        cnt_load = bus.frame_sync;
        cnt_en   = !bus.frame_sync;
      end
    end
  end

  mod_n_counter #(.W(SEL_W), .MOD(N_CH)) u_slot_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .load1 (cnt_load),
    .cnt   (slot),
    .wrap  (cnt_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_HUNT;
      bus.ch_data     <= '0;
      bus.ch_strobe   <= '0;
      bus.ch_sel      <= '0;
      bus.frame_valid <= 1'b0;
      bus.sync_err    <= 1'b0;
      for (int i = 0; i < N_CH - 1; i++) work[i] <= '0;
    end else begin
      bus.ch_strobe   <= '0;
      bus.frame_valid <= 1'b0;
      bus.sync_err    <= 1'b0;
      if (bus.din_valid) begin
        if (state == ST_HUNT) begin
          if (bus.frame_sync) begin
            work[0]       <= bus.din;
            bus.ch_strobe <= N_CH'(1);
            bus.ch_sel    <= '0;
            state         <= ST_LOCKED;
          end
        end else if (slot == '0) begin
          if (bus.frame_sync) begin
            work[0]       <= bus.din;
            bus.ch_strobe <= N_CH'(1);
            bus.ch_sel    <= '0;
          end else begin
            bus.sync_err <= 1'b1;
            state        <= ST_HUNT;
          end
        end else if (bus.frame_sync) begin
          // Early sync: drop the partial frame, restart with this word.
          bus.sync_err  <= 1'b1;
          work[0]       <= bus.din;
          bus.ch_strobe <= N_CH'(1);
          bus.ch_sel    <= '0;
        end else begin
          for (int i = 1; i < N_CH - 1; i++) begin
            if (slot == SEL_W'(i)) work[i] <= bus.din;
          end
          bus.ch_strobe <= N_CH'(onehot_slot(4'(slot)));
          bus.ch_sel    <= slot;
          if (cnt_wrap) begin
            // Last channel: whole frame lands in ch_data in one edge.
            for (int i = 0; i < N_CH - 1; i++) bus.ch_data[i*WIDTH +: WIDTH] <= work[i];
            bus.ch_data[(N_CH-1)*WIDTH +: WIDTH] <= bus.din;
            bus.frame_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.locked    = (state == ST_LOCKED);
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_demux_tdm_1x4.sv
// Self-checking bench for demux_tdm_1x4 (WIDTH=8, N_CH=4): directed
// scenarios followed by randomized traffic, all checked against a
// frame-assembly model built on a queue of the words of the current frame.
module tb_demux_tdm_1x4;
  localparam int WIDTH = 8;
  localparam int N_CH  = 4;
  localparam int DW    = N_CH * WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_tdm_1x4_if #(.WIDTH(WIDTH), .N_CH(N_CH)) bus ();

  demux_tdm_1x4 #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] part[$];      // words of the frame being assembled
  logic [DW-1:0]    exp_q[$];     // completed frames awaiting frame_valid
  bit               m_locked;
  logic [DW-1:0]    m_data;
  logic [N_CH-1:0]  m_strobe;
  logic [1:0]       m_sel;
  logic             m_fv;
  logic             m_err;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void model_reset();
    part.delete();
    exp_q.delete();
    m_locked = 0;
    m_data   = '0;
    m_strobe = '0;
    m_sel    = '0;
    m_fv     = 0;
    m_err    = 0;
  endfunction

  function automatic void model_capture(input int k);
    m_strobe    = '0;
    m_strobe[k] = 1'b1;
    m_sel       = 2'(k);
  endfunction

  function automatic void model_step(input bit v, input bit fs, input logic [WIDTH-1:0] d);
    m_strobe = '0;
    m_fv     = 0;
    m_err    = 0;
    if (!v) return;
    if (!m_locked) begin
      if (fs) begin
        m_locked = 1;
        part.delete();
        part.push_back(d);
        model_capture(0);
      end
    end else if (part.size() == 0) begin
      if (fs) begin
        part.push_back(d);
        model_capture(0);
      end else begin
        m_err    = 1;
        m_locked = 0;
      end
    end else if (fs) begin
      m_err = 1;
      part.delete();
      part.push_back(d);
      model_capture(0);
    end else begin
      part.push_back(d);
      model_capture(part.size() - 1);
      if (part.size() == N_CH) begin
        for (int i = 0; i < N_CH; i++) m_data[i*WIDTH +: WIDTH] = part[i];
        exp_q.push_back(m_data);
        m_fv = 1;
        part.delete();
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    logic [DW-1:0] frame;
    check({tag, ".strobe"}, DW'(bus.ch_strobe), DW'(m_strobe));
    check({tag, ".sel"},    DW'(bus.ch_sel),    DW'(m_sel));
    check({tag, ".fv"},     DW'(bus.frame_valid), DW'(m_fv));
    check({tag, ".err"},    DW'(bus.sync_err),  DW'(m_err));
    check({tag, ".locked"}, DW'(bus.locked),    DW'(m_locked));
    check({tag, ".data"},   bus.ch_data,        m_data);
    if (m_fv) begin
      frame = exp_q.pop_front();
      check({tag, ".frame"}, bus.ch_data, frame);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic cycle(input bit r, input bit v, input bit fs, input logic [WIDTH-1:0] d,
                       input string tag);
    rst            = r;
    bus.din_valid  = v;
    bus.frame_sync = fs;
    bus.din        = d;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else   model_step(v, fs, d);
    check_outputs(tag);
  endtask

  task automatic word(input bit fs, input logic [WIDTH-1:0] d, input string tag);
    cycle(1'b0, 1'b1, fs, d, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom_range(0, 1), 8'($urandom), tag);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, $urandom_range(0, 1), $urandom_range(0, 1),
                                      8'($urandom), "reset");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    bus.din        = '0;
    model_reset();

    // Reset then idle
    do_reset(2);
    idle(5, "idle");

    // Lock and capture
    word(1, 8'h11, "lock0");
    word(0, 8'h22, "lock1");
    word(0, 8'h33, "lock2");
    word(0, 8'h44, "lock3");
    check("lock.const", bus.ch_data, 32'h44332211);
    idle(2, "lock_idle");

    // Stall between words 2 and 3
    word(1, 8'h11, "stall0");
    word(0, 8'h22, "stall1");
    idle(3, "stall_gap");
    word(0, 8'h33, "stall2");
    word(0, 8'h44, "stall3");
    check("stall.const", bus.ch_data, 32'h44332211);

    // Early sync
    word(1, 8'h11, "early0");
    word(0, 8'h22, "early1");
    word(1, 8'hAA, "early_sync");
    word(0, 8'hBB, "early3");
    word(0, 8'hCC, "early4");
    word(0, 8'hDD, "early5");
    check("early.const", bus.ch_data, 32'hDDCCBBAA);

    // Missing sync: full frame, then slot-0 word without sync
    word(1, 8'h01, "miss0");
    word(0, 8'h02, "miss1");
    word(0, 8'h03, "miss2");
    word(0, 8'h04, "miss3");
    word(0, 8'h05, "miss_nosync");
    word(0, 8'h06, "miss_ignored");
    word(0, 8'h07, "miss_ignored");
    word(1, 8'h10, "relock0");
    word(0, 8'h20, "relock1");
    word(0, 8'h30, "relock2");
    word(0, 8'h40, "relock3");
    check("relock.const", bus.ch_data, 32'h40302010);

    // Reset mid-frame, then a clean frame
    word(1, 8'h55, "mid0");
    word(0, 8'h66, "mid1");
    do_reset(1);
    check("mid.data_cleared", bus.ch_data, 32'h0);
    word(1, 8'h9A, "post0");
    word(0, 8'hBC, "post1");
    word(0, 8'hDE, "post2");
    word(0, 8'hF0, "post3");
    check("post.const", bus.ch_data, 32'hF0DEBC9A);

    // Randomized traffic, sync mostly where a frame should start
    for (int i = 0; i < 600; i++) begin
      bit v, fs;
      v  = ($urandom_range(0, 99) < 75);
      if (!m_locked || part.size() == 0) fs = ($urandom_range(0, 99) < 85);
      else                               fs = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 199) == 0) cycle(1'b1, v, fs, 8'($urandom), "rand_rst");
      else                             cycle(1'b0, v, fs, 8'($urandom), "rand");
    end

    idle(2, "tail");
    check("tail.exp_q_empty", DW'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
